game_turn_ctrl: RTL and testbench
=================================

# game_turn_ctrl

Game-logic stage that drives `ui_render`, replacing the button-simulated position generator. It debounces a roll button, draws a 1–3 tile dice value from a free-running LFSR, and alternates between player 1 and player 2. For the active player it emits a new `pos_x` with a stretched `pos_valid`, then waits for that player's `turn_done` from `ui_render` before passing the turn. It detects the finish flag and supports a new-game restart.

## Interface
- `START_X`, 20: start pixel x for both players.
- `TILE_SPACING`, 60: pixels per tile.
- `MAX_X`, 620: flag pixel x.
- `DEBOUNCE_CYCLES`, 1000000: stable-input cycles required by the debouncer (10 ms at 100 MHz).
- `VALID_STRETCH`, 4: `pos_valid` high time in `clk_100mhz` cycles. Must be ≥ 4 so the 25 MHz `ui_render` samples it.
- `clk_100mhz` input 1: clock.
- `btn_reset` input 1: reset, asynchronous, active-high.
- `btn_roll` input 1: raw roll / new-game button.
- `player1_pos_x` output 10: player 1 position.
- `player1_pos_valid` output 1: player 1 position update strobe.
- `player1_turn_done` input 1: player 1 animation complete, from the 25 MHz domain.
- `player2_pos_x` output 10: player 2 position.
- `player2_pos_valid` output 1: player 2 position update strobe.
- `player2_turn_done` input 1: player 2 animation complete, from the 25 MHz domain.
- `cur_player` output 1: 0 = player 1, 1 = player 2.
- `dice_value` output 2: last roll, 1..3; 0 before the first roll.
- `game_over` output 1: a player has reached `MAX_X`.
- `winner` output 2: 0 = none, 1 = player 1, 2 = player 2.

## Operation
- Reset values:
  - Both `pos_x` = `START_X`.
  - Both `pos_valid` = 0; `cur_player` = 0; `dice_value` = 0; `game_over` = 0; `winner` = 0.
  - FSM = IDLE; LFSR = 8'hA5.
- Roll button:
  - `btn_roll` passes through a 2-flop synchronizer, then the debouncer.
  - A rising edge of the debounced level gives a 1-cycle `roll_pulse`.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle.
  - Never reaches zero (seed is nonzero).
  - `die = (lfsr % 3) + 1`.
- `turn_done` inputs: each passes through a 2-flop synchronizer and rising-edge detect.
- FSM states:
  - **IDLE**: `roll_pulse` → ROLL.
  - **ROLL**:
    - Latch `dice_value` = `die`.
    - Compute `sum` = `pos_x[cur]` + `die`·`TILE_SPACING`, 11-bit, no overflow.
    - → MOVE, or → CHECK if the move is rejected (see Configuration).
  - **MOVE**:
    - Write the new `pos_x[cur]` and assert `pos_valid[cur]` for `VALID_STRETCH` cycles.
    - The other player's outputs are untouched.
    - → WAIT_DONE.
  - **WAIT_DONE**:
    - A synchronized `turn_done` rising edge of the current player → CHECK.
    - The other player's `turn_done` is ignored.
  - **CHECK**:
    - If `pos_x[cur]` == `MAX_X`: `game_over` = 1, `winner` = `cur`+1 → OVER.
    - Otherwise toggle `cur_player` → IDLE.
  - **OVER**: `roll_pulse` → NEWGAME.
  - **NEWGAME**:
    - Both `pos_x` = `START_X`; both `pos_valid` high for `VALID_STRETCH` cycles.
    - `cur_player` = 0; `game_over` = 0; `winner` = 0; `dice_value` = 0.
    - → IDLE.
- `roll_pulse` is ignored in ROLL, MOVE, WAIT_DONE, CHECK and NEWGAME. There is no queuing.
- `turn_done` edges are ignored outside WAIT_DONE.
- An asynchronous reset in any state returns every output and the FSM to reset values immediately.

## Timing
- `roll_pulse` arrives `DEBOUNCE_CYCLES` + 3 cycles after `btn_roll` settles high.
- Roll-to-update latency:
  - `roll_pulse` in cycle t → ROLL in t+1.
  - `pos_x` updated and `pos_valid` high from t+2 through t+1+`VALID_STRETCH`.
- `pos_x` is stable from the first valid cycle until the next update.
- A `turn_done` rising edge at the input is seen in WAIT_DONE 3 cycles later; CHECK follows 1 cycle after that.
- `cur_player` toggles 1 cycle after CHECK.
- Valid pulses are never back-to-back for the same player. The minimum gap is a full WAIT_DONE.

## Configuration
- `GAME_EXACT_FINISH_EN` defined:
  - If `sum` > `MAX_X`, the move is rejected: `pos_x` is unchanged and no `pos_valid` is issued.
  - The FSM goes ROLL → CHECK directly, so the turn passes.
- `GAME_EXACT_FINISH_EN` undefined: if `sum` > `MAX_X`, the new position is clamped to `MAX_X`, and the move proceeds through MOVE / WAIT_DONE.

## Structure
- Package `game_pkg`:
  - Constants: `START_X`, `TILE_SPACING`, `MAX_X`, LFSR seed and taps.
  - Typedef `state_t` enum: IDLE, ROLL, MOVE, WAIT_DONE, CHECK, OVER, NEWGAME.
  - Typedef `player_t`.
- Sub-module `btn_debounce`:
  - Synchronizer, stability counter of `DEBOUNCE_CYCLES`, rising-edge pulse out.
  - Clocked by `clk_100mhz`, reset by `btn_reset`.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES` = 4.
- Reset → both `pos_x` = 20, both valids 0, `cur_player` 0, `dice_value` 0, `game_over` 0, `winner` 0.
- Force LFSR die = 2, press roll → `player1_pos_x` = 140 with `player1_pos_valid` high exactly 4 cycles; `player2` outputs unchanged.
- Pulse `player2_turn_done` during player 1's WAIT_DONE → ignored. Then pulse `player1_turn_done` → `cur_player` = 1 within 5 cycles.
- Press roll during WAIT_DONE → no new valid and `dice_value` unchanged.
- Player 1 at 560, die = 3:
  - With `GAME_EXACT_FINISH_EN` → no valid, `pos_x` stays 560, `cur_player` toggles.
  - Without the macro → `pos_x` = 620, then after `turn_done`: `game_over` = 1, `winner` = 1.
- In OVER, press roll → both `pos_x` = 20 with both valids high for 4 cycles, `winner` = 0, `cur_player` = 0. Assert `btn_reset` during MOVE → all outputs at reset values the same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared constants, state/player types and LFSR step for the turn controller.
package game_pkg;
  localparam int START_X = 20;
  localparam int TILE_SPACING = 60;
  localparam int MAX_X = 620;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 maps onto register bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  typedef enum logic [2:0] {IDLE, ROLL, MOVE, WAIT_DONE, CHECK, OVER, NEWGAME} state_t;
  typedef logic player_t;
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/game_turn_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and registered rising-edge pulse.
module btn_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk_100mhz,
  input  logic btn_reset,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic level_q, level_prev_q;
  always_ff @(posedge clk_100mhz or posedge btn_reset)
    if (btn_reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] == level_q) cnt_q <= '0;
      else if (cnt_q == CW'(CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
      level_prev_q <= level_q;
      pulse_o <= level_q & ~level_prev_q;
    end
endmodule

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: two-player dice turn sequencer feeding ui_render.
// GAME_EXACT_FINISH_EN rejects overshooting moves instead of clamping them to MAX_X.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int VALID_STRETCH = 4
) (
  input  logic       clk_100mhz,
  input  logic       btn_reset,
  input  logic       btn_roll,
  output logic [9:0] player1_pos_x,
  output logic       player1_pos_valid,
  input  logic       player1_turn_done,
  output logic [9:0] player2_pos_x,
  output logic       player2_pos_valid,
  input  logic       player2_turn_done,
  output logic       cur_player,
  output logic [1:0] dice_value,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int VW = $clog2(VALID_STRETCH + 1);
  state_t state_q, state_d;
  logic [7:0] lfsr_q;
  logic [1:0][9:0] pos_q, pos_d;
  logic [1:0] vmask_q, vmask_d, dice_q, dice_d, winner_q, winner_d, done_p_q, die;
  logic [VW-1:0] vcnt_q, vcnt_d;
  player_t cur_q, cur_d;
  logic over_q, over_d, roll_pulse, reject;
  logic [1:0][2:0] done_sync_q;
  logic [10:0] sum;
  logic [9:0] target;
  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_roll (
    .clk_100mhz(clk_100mhz),
    .btn_reset(btn_reset),
    .btn_i(btn_roll),
    .pulse_o(roll_pulse)
  );
  assign die = 2'(lfsr_q % 8'd3 + 8'd1);
  assign sum = 11'({1'b0, pos_q[cur_q]} + die * TILE_SPACING);
  assign target = (sum > 11'(MAX_X)) ? 10'(MAX_X) : sum[9:0];
`ifdef GAME_EXACT_FINISH_EN
  assign reject = sum > 11'(MAX_X);
`else
  assign reject = 1'b0;
`endif
  always_ff @(posedge clk_100mhz or posedge btn_reset)
    if (btn_reset) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      pos_q <= {2{10'(START_X)}};
      vmask_q <= '0;
      vcnt_q <= '0;
      cur_q <= 1'b0;
      dice_q <= '0;
      over_q <= 1'b0;
      winner_q <= '0;
      done_sync_q <= '0;
      done_p_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_next(lfsr_q);
      pos_q <= pos_d;
      vmask_q <= vmask_d;
      vcnt_q <= vcnt_d;
      cur_q <= cur_d;
      dice_q <= dice_d;
      over_q <= over_d;
      winner_q <= winner_d;
      done_sync_q[0] <= {done_sync_q[0][1:0], player1_turn_done};
      done_sync_q[1] <= {done_sync_q[1][1:0], player2_turn_done};
      done_p_q <= {done_sync_q[1][1] & ~done_sync_q[1][2], done_sync_q[0][1] & ~done_sync_q[0][2]};
    end
  // position and strobe are registered on entry to MOVE/NEWGAME so valid rises with the state
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    vmask_d = vmask_q;
    vcnt_d = vcnt_q - VW'(vcnt_q != '0);
    cur_d = cur_q;
    dice_d = dice_q;
    over_d = over_q;
    winner_d = winner_q;
    unique case (state_q)
      IDLE: state_d = roll_pulse ? ROLL : IDLE;
      ROLL: begin
        dice_d = die;
        state_d = reject ? CHECK : MOVE;
        if (!reject) begin
          pos_d[cur_q] = target;
          vmask_d = cur_q ? 2'b10 : 2'b01;
          vcnt_d = VW'(VALID_STRETCH);
        end
      end
      MOVE: state_d = WAIT_DONE;
      WAIT_DONE: state_d = done_p_q[cur_q] ? CHECK : WAIT_DONE;
      CHECK: begin
        if (pos_q[cur_q] == 10'(MAX_X)) begin
          over_d = 1'b1;
          winner_d = cur_q ? 2'd2 : 2'd1;
          state_d = OVER;
        end else begin
          cur_d = ~cur_q;
          state_d = IDLE;
        end
      end
      OVER: if (roll_pulse) begin
        state_d = NEWGAME;
        pos_d = {2{10'(START_X)}};
        vmask_d = 2'b11;
        vcnt_d = VW'(VALID_STRETCH);
        cur_d = 1'b0;
        over_d = 1'b0;
        winner_d = '0;
        dice_d = '0;
      end
      NEWGAME: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign player1_pos_x = pos_q[0];
  assign player2_pos_x = pos_q[1];
  assign player1_pos_valid = vmask_q[0] & (vcnt_q != '0);
  assign player2_pos_valid = vmask_q[1] & (vcnt_q != '0);
  assign cur_player = cur_q;
  assign dice_value = dice_q;
  assign game_over = over_q;
  assign winner = winner_q;
endmodule

// File: tb/tb_game_turn_ctrl.sv
// tb_game_turn_ctrl: directed turn table plus hand sequences for the turn controller.
module tb_game_turn_ctrl;
  typedef struct {
    int p;
    int die;
    int pos;
    bit valid;
    bit over;
  } turn_t;
  logic clk_100mhz = 1'b0, btn_reset, btn_roll, player1_turn_done, player2_turn_done;
  logic [9:0] player1_pos_x, player2_pos_x;
  logic player1_pos_valid, player2_pos_valid, cur_player, game_over;
  logic [1:0] dice_value, winner;
  logic [7:0] m_lfsr;
  int n_chk = 0, n_fail = 0, v_first, v_cnt1, v_cnt2, tog_k;
  int exp_pos[2];
  logic [9:0] v_pos1, v_pos2;
  turn_t tv[$];
  game_turn_ctrl #(.DEBOUNCE_CYCLES(4), .VALID_STRETCH(4)) dut (
    .clk_100mhz(clk_100mhz),
    .btn_reset(btn_reset),
    .btn_roll(btn_roll),
    .player1_pos_x(player1_pos_x),
    .player1_pos_valid(player1_pos_valid),
    .player1_turn_done(player1_turn_done),
    .player2_pos_x(player2_pos_x),
    .player2_pos_valid(player2_pos_valid),
    .player2_turn_done(player2_turn_done),
    .cur_player(cur_player),
    .dice_value(dice_value),
    .game_over(game_over),
    .winner(winner)
  );
  always #5 clk_100mhz = ~clk_100mhz;
  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction
  // independent reference of the free-running die source
  always @(posedge clk_100mhz or posedge btn_reset)
    if (btn_reset) m_lfsr <= 8'hA5;
    else m_lfsr <= nxt(m_lfsr);
  // press after edge e0 -> roll_pulse after e0+7 -> ROLL cycle reads the LFSR value after e0+8
  function automatic int pred_die();
    logic [7:0] l;
    l = m_lfsr;
    repeat (8) l = nxt(l);
    return int'(l % 8'd3) + 1;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask
  task automatic press_and_watch(input int die);
    int guard;
    guard = 0;
    while (die != 0 && pred_die() != die && guard < 300) begin
      tick();
      guard++;
    end
    if (guard >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL die_search: die %0d never predicted", die);
    end
    btn_roll = 1'b1;
    v_first = -1;
    v_cnt1 = 0;
    v_cnt2 = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 10) btn_roll = 1'b0;
      if (player1_pos_valid) begin v_cnt1++; v_pos1 = player1_pos_x; end
      if (player2_pos_valid) begin v_cnt2++; v_pos2 = player2_pos_x; end
      if ((player1_pos_valid || player2_pos_valid) && v_first < 0) v_first = k;
    end
  endtask
  task automatic pulse_done(input int p);
    logic c0;
    c0 = cur_player;
    tog_k = -1;
    if (p == 1) player1_turn_done = 1'b1;
    else player2_turn_done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 4) begin player1_turn_done = 1'b0; player2_turn_done = 1'b0; end
      if (tog_k < 0 && cur_player !== c0) tog_k = k;
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_p1_pos"}, player1_pos_x, 20);
    check({tag, "_p2_pos"}, player2_pos_x, 20);
    check({tag, "_p1_valid"}, player1_pos_valid, 0);
    check({tag, "_p2_valid"}, player2_pos_valid, 0);
    check({tag, "_cur"}, cur_player, 0);
    check({tag, "_dice"}, dice_value, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_winner"}, winner, 0);
  endtask
  initial begin
    tv.push_back('{2, 1, 80, 1, 0});
    tv.push_back('{1, 3, 320, 1, 0});
    tv.push_back('{2, 1, 140, 1, 0});
    tv.push_back('{1, 3, 500, 1, 0});
    tv.push_back('{2, 2, 260, 1, 0});
    tv.push_back('{1, 1, 560, 1, 0});
    tv.push_back('{2, 1, 320, 1, 0});
`ifdef GAME_EXACT_FINISH_EN
    tv.push_back('{1, 3, 560, 0, 0});
    tv.push_back('{2, 1, 380, 1, 0});
    tv.push_back('{1, 1, 620, 1, 1});
`else
    tv.push_back('{1, 3, 620, 1, 1});
`endif
    btn_reset = 1'b1;
    btn_roll = 1'b0;
    player1_turn_done = 1'b0;
    player2_turn_done = 1'b0;
    repeat (3) @(posedge clk_100mhz);
    #1;
    check_reset_outputs("reset");
    btn_reset = 1'b0;
    tick();
    tick();
    press_and_watch(2);
    check("t1_pos", v_pos1, 140);
    check("t1_valid_len", v_cnt1, 4);
    check("t1_valid_start", v_first, 9);
    check("t1_p2_valid", v_cnt2, 0);
    check("t1_p2_pos", player2_pos_x, 20);
    check("t1_dice", dice_value, 2);
    check("t1_pos_hold", player1_pos_x, 140);
    pulse_done(2);
    check("wrong_done_cur", cur_player, 0);
    check("wrong_done_tog", tog_k, -1);
    press_and_watch(0);
    check("wait_roll_valid", v_cnt1 + v_cnt2, 0);
    check("wait_roll_dice", dice_value, 2);
    pulse_done(1);
    check("done_latency", tog_k, 5);
    check("done_cur", cur_player, 1);
    exp_pos = '{140, 20};
    foreach (tv[i]) begin
      press_and_watch(tv[i].die);
      exp_pos[tv[i].p - 1] = tv[i].pos;
      check($sformatf("turn%0d_dice", i), dice_value, tv[i].die);
      check($sformatf("turn%0d_p1_pos", i), player1_pos_x, exp_pos[0]);
      check($sformatf("turn%0d_p2_pos", i), player2_pos_x, exp_pos[1]);
      check($sformatf("turn%0d_p1_vcnt", i), v_cnt1, (tv[i].valid && tv[i].p == 1) ? 4 : 0);
      check($sformatf("turn%0d_p2_vcnt", i), v_cnt2, (tv[i].valid && tv[i].p == 2) ? 4 : 0);
      if (tv[i].valid) pulse_done(tv[i].p);
      check($sformatf("turn%0d_over", i), game_over, tv[i].over);
      check($sformatf("turn%0d_winner", i), winner, tv[i].over ? tv[i].p : 0);
      check($sformatf("turn%0d_cur", i), cur_player, tv[i].over ? tv[i].p - 1 : 2 - tv[i].p);
    end
    press_and_watch(0);
    check("ng_p1_vcnt", v_cnt1, 4);
    check("ng_p2_vcnt", v_cnt2, 4);
    check("ng_valid_start", v_first, 8);
    check("ng_p1_pos", v_pos1, 20);
    check("ng_p2_pos", v_pos2, 20);
    check("ng_over", game_over, 0);
    check("ng_winner", winner, 0);
    check("ng_cur", cur_player, 0);
    check("ng_dice", dice_value, 0);
    btn_roll = 1'b1;
    for (int k = 1; k <= 9; k++) tick();
    check("move_valid", player1_pos_valid, 1);
    btn_reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    btn_roll = 1'b0;
    tick();
    btn_reset = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
